// File: rtl/mem_ctrl.sv
// Word-addressed instruction/data memory controller with a sticky fault flag.
// Optional wait-state FSM is enabled by defining MEM_WAIT_EN.
module mem_ctrl #(
  parameter int IM_L     = 8,
  parameter int DM_L     = 128,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        write,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [31:0] prog_data,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);
  localparam int IW = (IM_L > 1) ? $clog2(IM_L) : 1;
  localparam int DW = (DM_L > 1) ? $clog2(DM_L) : 1;

  logic [31:0] im [IM_L];
  logic [31:0] dm [DM_L];

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_write;
  logic        first_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        new_req;
  logic        capture;
  logic        do_access;
  logic [23:0] acc_hi;
  logic [5:0]  acc_lo;
  logic        acc_write;
  logic [31:0] acc_wdata;
  logic        acc_is_im;
  logic        acc_fault;
  logic [31:0] acc_rd;
  logic        dm_we;

  // Any difference from the captured tuple (or the first cycle out of reset) is a new request.
  assign new_req = first_q || (addr != cap_addr) || (write != cap_write) || (wdata != cap_wdata);

`ifdef MEM_WAIT_EN
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic        ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (new_req) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_CYC - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture)
        ready_q <= 1'b0;
      else if (do_access)
        ready_q <= 1'b1;
    end
  end

  // The access always uses the tuple captured when the request was accepted.
  assign acc_hi    = cap_addr[31:8];
  assign acc_lo    = cap_addr[7:2];
  assign acc_write = cap_write;
  assign acc_wdata = cap_wdata;
  assign ready     = ready_q;
`else
  assign capture   = new_req;
  assign do_access = new_req;
  assign acc_hi    = addr[31:8];
  assign acc_lo    = addr[7:2];
  assign acc_write = write;
  assign acc_wdata = wdata;
  assign ready     = ~rst;
`endif

  always_comb begin
    acc_is_im = (acc_hi == 24'd0);
    acc_fault = 1'b0;
    acc_rd    = 32'd0;
    if (acc_is_im) begin
      // The instruction region is read-only from the CPU side.
      acc_fault = acc_write || ({26'd0, acc_lo} >= IM_L);
      if (!acc_fault)
        acc_rd = im[IW'(acc_lo)];
    end else begin
      acc_fault = ({8'd0, acc_hi} >= DM_L);
      if (!acc_fault)
        acc_rd = acc_write ? acc_wdata : dm[DW'(acc_hi)];
    end
  end

  assign dm_we = do_access && acc_write && !acc_fault && !acc_is_im && !rst;

  always_ff @(posedge clk) begin
    if (rst && prog_we && ({24'd0, prog_addr} < IM_L))
      im[IW'(prog_addr)] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (dm_we)
      dm[DW'(acc_hi)] <= acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_write <= 1'b0;
      first_q   <= 1'b1;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (capture) begin
        cap_addr  <= addr;
        cap_wdata <= wdata;
        cap_write <= write;
        first_q   <= 1'b0;
      end
      if (do_access) begin
        rdata_q <= acc_rd;
        if (acc_fault)
          err_q <= 1'b1;
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter IM_L, default 8: instruction-memory depth in 32-bit words.
REQ-002 Parameter DM_L, default 128: data-memory depth in 32-bit words.
REQ-003 Parameter WAIT_CYC, default 2 (legal 1..15): wait states per access when MEM_WAIT_EN is defined.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 addr  input  32  byte address from the CPU.
REQ-007 wdata  input  32  store data.
REQ-008 write  input  1  1 = store, 0 = load/fetch.
REQ-009 prog_we  input  1  instruction-memory program strobe, honoured only while rst=1.
REQ-010 prog_addr  input  8  instruction word index for programming.
REQ-011 prog_data  input  32  instruction word for programming.
REQ-012 rdata  output  32  registered read data.
REQ-013 ready  output  1  1 = idle, with rdata valid for the last accepted request.
REQ-014 err  output  1  sticky access-fault flag.

Function
REQ-015 Decode SHALL select IM when addr[31:8]==0, with word index addr[7:2] and addr[1:0] ignored; otherwise DM, with word index addr[31:8].
REQ-016 An IM index >= IM_L, a DM index >= DM_L, or any write to the IM region SHALL be a fault: err<=1, read returns 0, write dropped.
REQ-017 States SHALL be S_IDLE (ready=1) and S_WAIT (ready=0).
REQ-018 In S_IDLE, a new request SHALL be any cycle where {addr,write,wdata} differs from the captured tuple, or the first cycle after reset.
REQ-019 On a new request in S_IDLE the tuple SHALL be captured, counter<=WAIT_CYC-1, and state<=S_WAIT.
REQ-020 S_WAIT SHALL decrement the counter; at counter==0 it SHALL perform the access using the captured tuple and go to S_IDLE.
REQ-021 Latency: request sampled at edge N -> ready=0 for edges N+1..N+WAIT_CYC; ready=1 with valid rdata from edge N+WAIT_CYC+1.
REQ-022 Inputs changing during S_WAIT SHALL be ignored; the change is detected as a new request on the first S_IDLE cycle.
REQ-023 A load SHALL set rdata<=mem[index]; a valid store SHALL set DM[index]<=wdata and rdata<=wdata.
REQ-024 Repeated identical tuples SHALL NOT re-access memory; rdata and ready hold.

Reset
REQ-025 While rst=1: state<=S_IDLE, ready<=0, rdata<=0, err<=0, captured tuple cleared, first-request flag<=1.
REQ-026 While rst=1, prog_we=1 with prog_addr<IM_L SHALL write IM[prog_addr]<=prog_data; other prog_addr values are ignored; prog_we=0 or rst=0 ignores the program port.
REQ-027 Reset during S_WAIT SHALL abort the access with no DM write; memory contents SHALL survive reset.

Configuration
REQ-028 Macro MEM_WAIT_EN defined: wait-state FSM per REQ-017..REQ-022.
REQ-029 MEM_WAIT_EN undefined: no S_WAIT; each new request is accessed in its sampling cycle, rdata is valid at the next edge, and ready=1 whenever rst=0. REQ-016, REQ-018, REQ-023 and REQ-024 still apply.

Verification (WAIT_CYC=2, MEM_WAIT_EN defined unless stated)
REQ-030 Program IM[0]=0x00000033 and IM[1]=0x00402083 under rst, release, addr=0x0 -> ready=0 for 2 cycles, then ready=1 and rdata=0x00000033.
REQ-031 Store addr=0x00000500, wdata=0xDEADBEEF -> after 2 wait cycles rdata=0xDEADBEEF; then load addr=0x500 -> rdata=0xDEADBEEF, err=0.
REQ-032 Load addr=0x00008000 (DM index 128) -> rdata=0, err=1; err stays 1 through later valid accesses until rst.
REQ-033 Store addr=0x600, wdata=0x12345678, rst asserted in the first S_WAIT cycle -> ready=0 during reset; a later load of 0x600 returns the pre-store value.
REQ-034 Request addr=0x4, then change to addr=0x8 during S_WAIT -> response rdata=IM[1]; one S_IDLE cycle later a new request starts, ending with rdata=IM[2].
REQ-035 MEM_WAIT_EN undefined, addr=0x4 -> rdata=0x00402083 at the next edge, ready constantly 1 after reset.
